// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter.
// Holds the arbiter state encoding, the requester count and the grant-index
// width. Every other file in this block imports it.
package rr_arbiter_pkg;

  // Arbiter state: no grant outstanding, or one grant held.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Number of requesters; this revision is fixed at 8.
  localparam int N_REQ = 8;

  // Width of the binary grant index.
  localparam int GID_W = 3;

endpackage : rr_arbiter_pkg

// File: rtl/rr_arbiter_pick.sv
// rr_pick: combinational round-robin winner selection.
// Rotates the request vector so that bit ptr lands at position 0, finds the
// lowest set bit of the rotated vector, then adds ptr back (mod 8) to recover
// the absolute requester index.
// Ports:
//   req   - request vector, bit i = requester i
//   ptr   - requester index to start the upward scan from
//   idx   - winning requester index (valid when found=1, 0 otherwise)
//   found - high when at least one request bit is set
module rr_pick
  import rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic [GID_W-1:0] idx,
  output logic             found
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [2*N_REQ-1:0] shifted_s;
  logic [N_REQ-1:0]   rot_s;
  logic [GID_W-1:0]   enc_s;
  logic               found_s;

  // Rotate req right by ptr using a doubled copy so the wrap comes for free.
  always_comb begin
    dbl_s     = {req, req};
    shifted_s = dbl_s >> ptr;
    rot_s     = shifted_s[N_REQ-1:0];
  end

  // Priority-encode the lowest set bit; scanning downward lets the lowest
  // set bit overwrite any higher one.
  always_comb begin
    enc_s   = {GID_W{1'b0}};
    found_s = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        enc_s   = GID_W'(i);
        found_s = 1'b1;
      end else begin
        enc_s   = enc_s;
      end
    end
  end

  // Undo the rotation; the 3-bit add wraps mod 8 naturally.
  always_comb begin
    if (found_s) begin
      idx = enc_s + ptr;
    end else begin
      idx = {GID_W{1'b0}};
    end
    found = found_s;
  end

endmodule : rr_pick

// File: rtl/rr_arbiter.sv
// rr_arbiter: 8-way round-robin arbiter with bounded hold time.
// A grant is held until the owner signals done, drops its request, or has
// held the resource for MAX_HOLD cycles. On release the arbiter re-arbitrates
// in the same cycle starting just above the released owner, so a new grant
// follows with no idle bubble and the released owner only wins again when it
// is the sole requester.
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   req         - request vector
//   done        - current owner finished (ignored while idle)
//   grant       - registered one-hot grant, or all-zero
//   grant_id    - registered binary index of the grant (valid with grant_valid)
//   grant_valid - registered, high while a grant bit is high
//   timeout     - one-cycle pulse after a release caused only by MAX_HOLD
module rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  import rr_arbiter_pkg::*;

  // Hold-counter value at which the current grant must be given up.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;
  logic [GID_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;

  logic [GID_W-1:0] pick_ptr_s;
  logic [GID_W-1:0] pick_idx_s;
  logic             pick_found_s;
  logic             owner_req_s;
  logic             at_max_s;
  logic             release_s;

  // While busy the scan must start just above the owner, which is exactly the
  // pointer value a release would load; while idle it starts at ptr_q.
  always_comb begin
    if (state_q == BUSY) begin
      pick_ptr_s = grant_id_q + 3'd1;
    end else begin
      pick_ptr_s = ptr_q;
    end
  end

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Release conditions for the current owner.
  always_comb begin
    owner_req_s = req[grant_id_q];
    at_max_s    = (hold_cnt_q == HOLD_LAST);
    release_s   = done || !owner_req_s || at_max_s;
  end

  // Next-state and next-output logic for the IDLE/BUSY machine.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d       = BUSY;
          grant_d       = N_REQ'(8'd1) << pick_idx_s;
          grant_id_d    = pick_idx_s;
          grant_valid_d = 1'b1;
          hold_cnt_d    = 8'd0;
        end else begin
          grant_d       = {N_REQ{1'b0}};
          grant_valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (release_s) begin
          ptr_d      = pick_ptr_s;
          hold_cnt_d = 8'd0;
          // Only a pure hold-limit expiry is reported as a timeout.
          timeout_d  = at_max_s && !done && owner_req_s;
          if (pick_found_s) begin
            state_d       = BUSY;
            grant_d       = N_REQ'(8'd1) << pick_idx_s;
            grant_id_d    = pick_idx_s;
            grant_valid_d = 1'b1;
          end else begin
            state_d       = IDLE;
            grant_d       = {N_REQ{1'b0}};
            grant_id_d    = {GID_W{1'b0}};
            grant_valid_d = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = {N_REQ{1'b0}};
        grant_id_d    = {GID_W{1'b0}};
        grant_valid_d = 1'b0;
        ptr_d         = {GID_W{1'b0}};
        hold_cnt_d    = 8'd0;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= {N_REQ{1'b0}};
      grant_id_q    <= {GID_W{1'b0}};
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= {GID_W{1'b0}};
      hold_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: a cycle-level reference model of the
// arbitration rules is compared against the DUT at every falling edge, and
// directed scenarios pin both DUT and model to hand-computed values.
module tb_rr_arbiter;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arbiter #(.N_REQ(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Model state: owner = -1 means nobody holds the resource.
  typedef struct packed {
    int owner;
    int ptr;
    int hold;
    bit to;
  } mstate_t;

  mstate_t m;

  function automatic int find_winner(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (start + k) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [7:0] r, input logic d);
    mstate_t n;
    n = s;
    n.to = 1'b0;
    if (s.owner < 0) begin
      n.owner = find_winner(r, s.ptr);
      n.hold  = 0;
    end else begin
      bit by_max, dropped;
      by_max  = (s.hold + 1 >= MAX_HOLD);
      dropped = !r[s.owner];
      if (d || dropped || by_max) begin
        n.ptr   = (s.owner + 1) % 8;
        n.to    = by_max && !d && !dropped;
        n.owner = find_winner(r, n.ptr);
        n.hold  = 0;
      end else begin
        n.hold = s.hold + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{owner: -1, ptr: 0, hold: 0, to: 1'b0};
    else        m <= model_step(m, req, done);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge clk) begin
    int eg;
    eg = (m.owner < 0) ? 0 : (1 << m.owner);
    check("model_grant", int'(grant), eg);
    check("model_valid", int'(grant_valid), (m.owner >= 0) ? 1 : 0);
    check("model_timeout", int'(timeout), int'(m.to));
    if (m.owner >= 0) check("model_grant_id", int'(grant_id), m.owner);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exp_seq[4];
    exp_seq = '{2, 4, 6, 0};

    repeat (3) tick();
    check("rst_grant", int'(grant), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_valid", int'(grant_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    tick();
    check("idle_no_req", int'(grant_valid), 0);

    // First grant one cycle after request.
    req = 8'b01010101;
    tick();
    check("first_grant", int'(grant), 1);
    check("first_grant_id", int'(grant_id), 0);

    // done every cycle walks the even requesters with no gaps.
    done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_seq_id", int'(grant_id), exp_seq[k]);
      check("rr_seq_valid", int'(grant_valid), 1);
    end
    done = 1'b0;

    // Sole requester held to the hold limit.
    req = 8'h00;
    tick();
    check("drop_to_idle", int'(grant_valid), 0);
    req = 8'b00100000;
    tick();
    check("hold_start", int'(grant), 8'h20);
    for (int k = 0; k < 14; k++) begin
      tick();
      check("hold_grant", int'(grant), 8'h20);
      check("hold_no_timeout", int'(timeout), 0);
    end
    tick();
    check("timeout_pulse", int'(timeout), 1);
    check("regrant_sole", int'(grant), 8'h20);
    tick();
    check("timeout_one_cycle", int'(timeout), 0);

    // done coinciding with the hold limit suppresses the pulse.
    req = 8'b00000100;
    tick();
    check("switch_to_2", int'(grant_id), 2);
    repeat (14) tick();
    done = 1'b1;
    tick();
    check("done_at_max_no_timeout", int'(timeout), 0);
    check("done_at_max_regrant", int'(grant_id), 2);
    done = 1'b0;

    // Owner dropping its request.
    req = 8'b00001000;
    tick();
    check("owner3", int'(grant_id), 3);
    req = 8'b10000001;
    tick();
    check("drop3_to_7", int'(grant_id), 7);
    done = 1'b1;
    tick();
    check("after7_to_0", int'(grant_id), 0);
    done = 1'b0;

    // Asynchronous reset between edges.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_valid", int'(grant_valid), 0);
    req = 8'b11000000;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_id", int'(grant_id), 6);

    // No requests: done must be ignored.
    req = 8'h00;
    tick();
    for (int k = 0; k < 30; k++) begin
      done = ($urandom_range(0, 1) == 1);
      tick();
      check("noreq_valid", int'(grant_valid), 0);
      check("noreq_timeout", int'(timeout), 0);
    end
    done = 1'b0;

    // Random traffic checked by the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) req = 8'($urandom_range(0, 255));
      done = ($urandom_range(0, 7) == 0);
      tick();
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_arbiter
